// File: rtl/shift_pkg.sv
// Shared types for the shift execution unit: opcode encoding, legality check and
// the S1 pipeline record (sized for the widest supported datapath, W <= 64, TAG_W <= 16).
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_t;

    localparam int unsigned S1_W_MAX   = 64;
    localparam int unsigned S1_TAG_MAX = 16;
    localparam int unsigned S1_AMT_W   = 6;

    function automatic logic op_is_legal(input op_t op);
        case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    typedef struct packed {
        logic                  is_right;
        logic                  is_arith;
        logic                  is_rotate;
        logic                  err;
        logic [S1_AMT_W-1:0]   amt;
        logic [S1_W_MAX-1:0]   a;
        logic [S1_TAG_MAX-1:0] tag;
    } s1_t;

endpackage

// File: rtl/bs.sv
// Combinational logarithmic barrel shifter: left/right, logical/arithmetic, rotate.
// One stage per amount bit; stage k moves the word by 2**k.
module bs #(
    parameter int W       = 32,
    parameter int SHIFT_W = $clog2(W)
) (
    input  logic [W-1:0]       a_i,
    input  logic [SHIFT_W-1:0] amt_i,
    input  logic               is_right_i,
    input  logic               is_arith_i,
    input  logic               is_rotate_i,
    output logic [W-1:0]       y_o
);

    logic [SHIFT_W:0][W-1:0] st;
    logic                    fill;

    // Sign bit is invariant through right shifts, so the fill can come from the input.
    assign fill  = is_arith_i & a_i[W-1];
    assign st[0] = a_i;

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        localparam int S = 1 << k;
        logic [W-1:0] rt;
        logic [W-1:0] lt;

        assign rt = {(is_rotate_i ? st[k][S-1:0] : {S{fill}}), st[k][W-1:S]};
        assign lt = {st[k][W-1-S:0], (is_rotate_i ? st[k][W-1:W-S] : {S{1'b0}})};
        assign st[k+1] = amt_i[k] ? (is_right_i ? rt : lt) : st[k];
    end

    assign y_o = st[SHIFT_W];

endmodule

// File: rtl/shift_unit.sv
// Two-stage flow-controlled shift unit: S1 holds decoded operands, S2 holds the result.
// Ready ripples backwards combinationally so the pipe runs at one op per cycle.
module shift_unit
    import shift_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  op_t              in_op_i,
    input  logic [W-1:0]     in_a_i,
    input  logic [W-1:0]     in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             flush_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [W-1:0]     out_y_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_err_o
);

    localparam int SHIFT_W = $clog2(W);

    s1_t              s1_d, s1_q;
    logic             s1_vld_q, s2_vld_q;
    logic [W-1:0]     y_d, y_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic [W-1:0]     bs_y;
    logic             s1_adv, s2_adv;

    assign s2_adv   = ~s2_vld_q | out_rdy_i;
    assign s1_adv   = ~s1_vld_q | s2_adv;
    assign in_rdy_o = s1_adv;

    always_comb begin
        s1_d     = '0;
        s1_d.err = ~op_is_legal(in_op_i);
        case (in_op_i)
            OP_SRL: s1_d.is_right = 1'b1;
            OP_SRA: begin
                s1_d.is_right = 1'b1;
                s1_d.is_arith = 1'b1;
            end
            OP_ROL: s1_d.is_rotate = 1'b1;
            OP_ROR: begin
                s1_d.is_right  = 1'b1;
                s1_d.is_rotate = 1'b1;
            end
            default: ;
        endcase
        s1_d.amt = S1_AMT_W'(in_b_i[SHIFT_W-1:0]);
        s1_d.a   = S1_W_MAX'(in_a_i);
        s1_d.tag = S1_TAG_MAX'(in_tag_i);
    end

    bs #(
        .W       (W),
        .SHIFT_W (SHIFT_W)
    ) u_bs (
        .a_i         (s1_q.a[W-1:0]),
        .amt_i       (s1_q.amt[SHIFT_W-1:0]),
        .is_right_i  (s1_q.is_right),
        .is_arith_i  (s1_q.is_arith),
        .is_rotate_i (s1_q.is_rotate),
        .y_o         (bs_y)
    );

    // Illegal ops still occupy a slot so ordering is preserved; only the data is squashed.
    assign y_d = s1_q.err ? '0 : bs_y;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            y_q      <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (flush_i)     s1_vld_q <= 1'b0;
            else if (s1_adv) s1_vld_q <= in_vld_i;
            if (s1_adv && in_vld_i && !flush_i) s1_q <= s1_d;

            if (flush_i)     s2_vld_q <= 1'b0;
            else if (s2_adv) s2_vld_q <= s1_vld_q;
            if (s2_adv && s1_vld_q && !flush_i) begin
                y_q   <= y_d;
                tag_q <= s1_q.tag[TAG_W-1:0];
                err_q <= s1_q.err;
            end
        end
    end

    assign out_vld_o = s2_vld_q;
    assign out_y_o   = y_q;
    assign out_tag_o = tag_q;
    assign out_err_o = err_q;

    // Upper record bits and upper shift-amount bits are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{s1_q, in_b_i};

endmodule

// File: tb/tb_shift_unit.sv
// Directed + short random bench for shift_unit with an in-order scoreboard.
module tb_shift_unit;
    import shift_pkg::*;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    op_t           in_op = OP_SLL;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          flush = 1'b0;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [W-1:0]  out_y;
    logic [TW-1:0] out_tag;
    logic          out_err;

    always #5 clk = ~clk;

    shift_unit #(.W(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_vld_i  (in_vld),
        .in_rdy_o  (in_rdy),
        .in_op_i   (in_op),
        .in_a_i    (in_a),
        .in_b_i    (in_b),
        .in_tag_i  (in_tag),
        .flush_i   (flush),
        .out_vld_o (out_vld),
        .out_rdy_i (out_rdy),
        .out_y_o   (out_y),
        .out_tag_o (out_tag),
        .out_err_o (out_err)
    );

    typedef struct packed {
        logic [W-1:0]  y;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TW-1:0] tag);
        int unsigned  n;
        logic [W-1:0] y;
        exp_t         e;
        n = int'(b[4:0]);
        case (op)
            3'd0:    y = a << n;
            3'd1:    y = a >> n;
            3'd2:    y = W'($signed(a) >>> n);
            3'd3:    y = (a << n) | (a >> (W - n));
            3'd4:    y = (a >> n) | (a << (W - n));
            default: y = '0;
        endcase
        e.y   = y;
        e.tag = tag;
        e.err = (op > 3'd4);
        return e;
    endfunction

    always @(negedge clk) begin
        if (arst_n) begin
            if (out_vld && out_rdy) begin
                chk("out_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("out_result", 64'({out_y, out_tag, out_err}), 64'(sb.pop_front()));
            end
            if (flush) sb.delete();
            else if (in_vld && in_rdy) sb.push_back(model(3'(in_op), in_a, in_b, in_tag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
        bit done = 1'b0;
        in_vld = 1'b1; in_op = op_t'(op); in_a = a; in_b = b; in_tag = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            look();
            done = in_rdy;
            step();
        end
        in_vld = 1'b0;
        chk("issue_accept", 64'(done), 64'd1);
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int i = 0; i < 50 && !empty; i++) begin
            look();
            empty = (sb.size() == 0) && !out_vld;
            step();
        end
        chk("drain", 64'(empty), 64'd1);
    endtask

    initial begin
        int acc;
        bit acc_now, held, pend;
        logic [W-1:0]  hold_y;
        logic [TW-1:0] hold_tag;

        // Reset state
        #12;
        chk("reset_outputs", 64'({out_vld, out_y, out_tag, out_err}), 64'd0);
        #10 arst_n = 1'b1;
        step();
        look();
        chk("post_reset", 64'({in_rdy, out_vld}), 64'b10);
        step();

        // SRA with latency check
        out_rdy = 1'b1;
        issue(3'd2, 32'h8000_0000, 32'd4, 4'd5);
        look();
        chk("sra_lat1", 64'(out_vld), 64'd0);
        step(); look();
        chk("sra_out", 64'({out_vld, out_y, out_tag, out_err}), 64'({1'b1, 32'hF800_0000, 4'd5, 1'b0}));
        step();

        // Back-to-back rotates
        issue(3'd4, 32'h0000_0001, 32'd1, 4'd6);
        issue(3'd3, 32'h8000_0001, 32'd4, 4'd7);
        look();
        chk("ror", 64'({out_vld, out_y}), 64'({1'b1, 32'h8000_0000}));
        step(); look();
        chk("rol", 64'({out_vld, out_y}), 64'({1'b1, 32'h0000_0018}));
        step();

        // Amount modulo W, zero amount
        issue(3'd0, 32'h0000_0003, 32'h0000_0021, 4'd8);
        issue(3'd1, 32'hFFFF_FFFF, 32'd0, 4'd9);
        look();
        chk("sll_mod", 64'({out_vld, out_y}), 64'({1'b1, 32'h0000_0006}));
        step(); look();
        chk("srl_zero", 64'({out_vld, out_y}), 64'({1'b1, 32'hFFFF_FFFF}));
        step();
        drain();

        // Back-pressure: three ops offered while the consumer stalls
        out_rdy = 1'b0;
        acc = 0; held = 1'b0; hold_y = '0; hold_tag = '0;
        in_vld = 1'b1; in_op = OP_SLL; in_a = 32'h11; in_b = 32'd1; in_tag = 4'd1;
        for (int c = 0; c < 5; c++) begin
            look();
            acc_now = in_rdy;
            if (out_vld && !held) begin
                held = 1'b1; hold_y = out_y; hold_tag = out_tag;
            end
            step();
            if (acc_now) begin
                acc++;
                in_a = 32'(acc + 1) * 32'h11; in_tag = 4'(acc + 1);
            end
        end
        look();
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_rdy", 64'(in_rdy), 64'd0);
        chk("bp_hold", 64'({held, out_tag, out_y}), 64'({1'b1, hold_tag, hold_y}));
        chk("bp_head_tag", 64'(out_tag), 64'd1);
        step();
        out_rdy = 1'b1;
        pend = 1'b1;
        for (int i = 0; i < 10 && pend; i++) begin
            look();
            acc_now = in_rdy;
            step();
            if (acc_now) pend = 1'b0;
        end
        in_vld = 1'b0;
        chk("bp_third_accept", 64'(pend), 64'd0);
        drain();

        // Flush with both stages full and a pending input
        out_rdy = 1'b0;
        issue(3'd0, 32'hA, 32'd1, 4'd10);
        issue(3'd0, 32'hB, 32'd1, 4'd11);
        in_vld = 1'b1; in_a = 32'hC; in_tag = 4'd12; flush = 1'b1;
        look();
        chk("flush_full", 64'({out_vld, in_rdy}), 64'b10);
        step();
        flush = 1'b0; in_vld = 1'b0;
        look();
        chk("flush_cleared", 64'({out_vld, in_rdy}), 64'b01);
        step();
        // Flush on an empty pipe discards a same-cycle input handshake
        out_rdy = 1'b1;
        in_vld = 1'b1; in_tag = 4'd13; flush = 1'b1;
        step();
        in_vld = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            look();
            chk("flush_quiet", 64'(out_vld), 64'd0);
            step();
        end

        // Illegal opcode
        issue(3'd6, 32'h1234_5678, 32'd5, 4'd14);
        look(); step(); look();
        chk("illegal", 64'({out_vld, out_y, out_err, out_tag}), 64'({1'b1, 32'd0, 1'b1, 4'd14}));
        step();
        drain();

        // Asynchronous reset with the pipe full
        out_rdy = 1'b0;
        issue(3'd0, 32'h1, 32'd1, 4'd2);
        issue(3'd0, 32'h2, 32'd1, 4'd3);
        look();
        chk("rst_prefull", 64'({out_vld, in_rdy}), 64'b10);
        #2 arst_n = 1'b0;
        #1;
        chk("rst_async", 64'({out_vld, out_y, out_tag, out_err}), 64'd0);
        sb.delete();
        #3 arst_n = 1'b1;
        step();
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("rst_release", 64'({in_rdy, out_vld}), 64'b10);
            step();
        end

        // Random traffic with random back-pressure
        for (int i = 0; i < 60; i++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_op   = op_t'(3'($urandom_range(0, 7)));
            in_a    = $urandom;
            in_b    = $urandom;
            in_tag  = 4'($urandom_range(0, 15));
            out_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_unit.md
# shift_unit

Pipelined, flow-controlled shift execution unit that wraps the combinational barrel shifter `bs`. It decodes a shift opcode into `bs` controls, registers operands, and registers the shifted result behind a valid/ready handshake. It sits in the integer execute path between issue and writeback, and supports flush and back-pressure.

## Interface
- `W`, default 32: datapath width; must be a power of two and at least 2.
- `TAG_W`, default 4: width of the opaque tag carried alongside each operation.
- `clk`  in  1: clock; all state changes on its rising edge.
- `arst_n`  in  1: reset, asynchronous active-low (**Already decided**: one clock; reset is asynchronous and active-low).
- `in_vld_i`  in  1: input operation valid.
- `in_rdy_o`  out  1: unit can accept an operation this cycle.
- `in_op_i`  in  3: opcode, as `shift_pkg::op_t`.
- `in_a_i`  in  W: value to shift.
- `in_b_i`  in  W: shift amount; only bits `[$clog2(W)-1:0]` are used.
- `in_tag_i`  in  TAG_W: tag, returned unchanged on the output.
- `flush_i`  in  1: kill all in-flight operations.
- `out_vld_o`  out  1: result valid.
- `out_rdy_i`  in  1: consumer accepts the result.
- `out_y_o`  out  W: shifted result.
- `out_tag_o`  out  TAG_W: tag of the result.
- `out_err_o`  out  1: the opcode was illegal.

## Operation
- Opcodes:
  - 0 SLL: left, zero fill.
  - 1 SRL: right, zero fill.
  - 2 SRA: right, sign fill.
  - 3 ROL: rotate left.
  - 4 ROR: rotate right.
  - 5..7: illegal.
- Decode to `bs` controls:
  - `is_right` = SRL | SRA | ROR.
  - `is_arith` = SRA.
  - `is_rotate` = ROL | ROR.
  - Shift amount = `in_b_i` modulo W. An amount of 0 returns `in_a_i` for every legal opcode.
- Illegal opcode: `out_y_o` = 0 and `out_err_o` = 1. The operation still flows through the pipe in order.
- Pipeline stage S1 (decode register) holds: valid, decoded controls, `a`, `amount`, tag, err.
  - `bs` evaluates combinationally from S1.
- Pipeline stage S2 (output register) holds: valid, y, tag, err. It drives the `out_*` ports directly.
- Per-stage handshake:
  - `s2_adv` = `~s2_vld | out_rdy_i`.
  - `s1_adv` = `~s1_vld | s2_adv`.
  - `in_rdy_o` = `s1_adv`.
  - Ready propagates combinationally backwards; no bubbles at full throughput.
- A stage loads only when it advances. While stalled, its contents are held bit-stable.
- Operations complete strictly in acceptance order.
- Flush (synchronous):
  - On an edge with `flush_i` = 1, `s1_vld` and `s2_vld` are both cleared.
  - An input handshake in the same cycle is discarded.
  - An output handshake in the same cycle is still considered consumed by the downstream consumer.
  - `in_rdy_o` is not gated by `flush_i`.
- Reset values: all valids 0. `out_y_o`, `out_tag_o`, `out_err_o` are 0. `in_rdy_o` is 1 once reset deasserts.
- Reset mid-operation: all in-flight operations are lost. No output appears after release until a new input is accepted.

## Timing
- Latency: an operation accepted on edge k is in S1 after k and appears on `out_*` after edge k+1.
  - `out_vld_o` rises in the cycle following acceptance plus one, i.e. 2 edges after the input handshake.
- Throughput: 1 op/cycle when `out_rdy_i` is held high.
- Full pipe (both valids set, `out_rdy_i` = 0): `in_rdy_o` = 0 in the same cycle.
- Full pipe, `out_rdy_i` = 1: a simultaneous input and output handshake in the same cycle is legal. Both stages shift.
- Maximum occupancy is 2. An empty pipe has `out_vld_o` = 0 and `in_rdy_o` = 1.
- `out_*` is registered. `in_rdy_o` is combinational from `out_rdy_i` and the state.

## Structure
- Package `shift_pkg`:
  - `op_t` enum (3-bit) with the encodings listed under Operation.
  - Function `op_is_legal`.
  - Struct `s1_t` holding the decoded controls, a, amount, tag and err.
- Sub-module: one instance of the existing barrel shifter `bs`, with `W` and `SHIFT_W = $clog2(W)`.
- No other hierarchy. The decode is a small combinational block inside `shift_unit`.

## Test plan
- SRA, a=0x8000_0000, b=4, `out_rdy_i`=1 → 2 edges later: y=0xF800_0000, err=0, tag echoed.
- Rotates, back-to-back:
  - ROR a=0x0000_0001 b=1 → 0x8000_0000.
  - ROL a=0x8000_0001 b=4 → 0x0000_0018.
  - Results arrive on consecutive cycles.
- SLL a=0x0000_0003 b=0x0000_0021 → amount 1, y=0x0000_0006.
  - SRL a=0xFFFF_FFFF b=0 → y=0xFFFF_FFFF.
- Back-pressure: issue 3 ops with tags 1, 2, 3 while `out_rdy_i`=0 for 5 cycles.
  - Exactly 2 ops are accepted; `in_rdy_o`=0 afterwards.
  - Output is held stable during the stall.
  - After release, tags arrive in order 1, 2, 3.
- Flush with both stages full and a simultaneous input → next cycle `out_vld_o`=0. None of the three ops ever appears.
- Reset and illegal opcode:
  - Opcode 6, a=0x1234_5678 → y=0, err=1.
  - Assert `arst_n` low while the pipe is full → all outputs go to 0 immediately. After release, `in_rdy_o`=1 and `out_vld_o`=0.
